// File: rtl/spike_encoder_pkg.sv
// Shared constants for the spike encoder: default geometry and FSM state encodings.
package spike_encoder_pkg;

    localparam int unsigned DEF_NUM_INPUTS = 64;
    localparam int unsigned DEF_TIMESTEPS  = 16;
    localparam int unsigned DEF_DATA_W     = 8;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEED   = 3'd1;
    localparam logic [2:0] ST_ENCODE = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/encoder_pixel_mem.sv
// Pixel intensity store: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module encoder_pixel_mem #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write of one pixel
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read feeds the comparator in the same cycle
    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: compares stored pixels with the external LFSR byte and
// streams one spike per pixel per timestep over a valid/ready interface.
// Optional feature: define SPIKE_COUNT_EN to add spike_count_o, a count of accepted
// beats carrying spike=1 (cleared at run start, held after completion).
module spike_encoder
    import spike_encoder_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int unsigned TIMESTEPS  = DEF_TIMESTEPS,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    localparam int unsigned IDX_W     = $clog2(NUM_INPUTS),
    localparam int unsigned TS_W      = $clog2(TIMESTEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_we_i,
    input  logic [IDX_W-1:0]  pix_addr_i,
    input  logic [DATA_W-1:0] pix_data_i,
    input  logic [DATA_W-1:0] seed_cfg_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] rand_i,
    output logic [DATA_W-1:0] seed_o,
    output logic              set_seed_o,
    output logic              spike_valid_o,
    input  logic              spike_ready_i,
    output logic              spike_o,
    output logic [IDX_W-1:0]  spike_idx_o,
    output logic [TS_W-1:0]   timestep_o,
    output logic              busy_o,
    output logic              done_o
`ifdef SPIKE_COUNT_EN
    ,
    output logic [IDX_W+TS_W:0] spike_count_o
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
    localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(TIMESTEPS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               valid_q, valid_d;
    logic               spike_q, spike_d;
    logic [IDX_W-1:0]   sidx_q, sidx_d;
    logic [TS_W-1:0]    sts_q, sts_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic               set_seed_q, set_seed_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_c;
    logic               pix_we_c;
    logic [DATA_W-1:0]  pix_rd_c;

    // Writes are only accepted while no run is in progress
    assign pix_we_c = pix_we_i && !busy_q;

    encoder_pixel_mem #(
        .DEPTH  (NUM_INPUTS),
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W)
    ) u_pix_mem (
        .clk       (clk),
        .we_i      (pix_we_c),
        .waddr_i   (pix_addr_i),
        .wdata_i   (pix_data_i),
        .raddr_i   (idx_q),
        .rdata_c_o (pix_rd_c)
    );

    // Next-state logic: FSM, scan counters, output beat register and status flags
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ts_d    = ts_q;
        valid_d = valid_q;
        spike_d = spike_q;
        sidx_d  = sidx_q;
        sts_d   = sts_q;
        load_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SEED;
                    idx_d   = '0;
                    ts_d    = '0;
                end
            end
            ST_SEED: begin
                // Output register is empty here, so the first beat loads on leaving SEED
                state_d = ST_ENCODE;
                load_c  = 1'b1;
            end
            ST_ENCODE: begin
                load_c = !valid_q || spike_ready_i;
                if (load_c && (idx_q == IDX_LAST) && (ts_q == TS_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!valid_q || spike_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load captures the current rand byte; stalled cycles simply skip theirs
        if (load_c) begin
            valid_d = 1'b1;
            spike_d = rand_i < pix_rd_c;
            sidx_d  = idx_q;
            sts_d   = ts_q;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                ts_d  = (ts_q == TS_LAST) ? '0 : ts_q + TS_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Abort overrides everything, including a simultaneous start
        if (abort_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            ts_d    = '0;
            valid_d = 1'b0;
            spike_d = 1'b0;
            sidx_d  = '0;
            sts_d   = '0;
        end

        // Status outputs are registered from the next state so they align with it
        set_seed_d = (state_d == ST_SEED);
        seed_d     = set_seed_d ? seed_cfg_i : '0;
        busy_d     = (state_d == ST_SEED) || (state_d == ST_ENCODE) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ts_q       <= '0;
            valid_q    <= 1'b0;
            spike_q    <= 1'b0;
            sidx_q     <= '0;
            sts_q      <= '0;
            seed_q     <= '0;
            set_seed_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ts_q       <= ts_d;
            valid_q    <= valid_d;
            spike_q    <= spike_d;
            sidx_q     <= sidx_d;
            sts_q      <= sts_d;
            seed_q     <= seed_d;
            set_seed_q <= set_seed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seed_o        = seed_q;
    assign set_seed_o    = set_seed_q;
    assign spike_valid_o = valid_q;
    assign spike_o       = spike_q;
    assign spike_idx_o   = sidx_q;
    assign timestep_o    = sts_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

`ifdef SPIKE_COUNT_EN
    localparam int unsigned CNT_W = IDX_W + TS_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count accepted beats carrying a spike; cleared as the run enters SEED
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ST_SEED) begin
            cnt_d = '0;
        end else if (valid_q && spike_ready_i && spike_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Spike counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: the driver pushes expected beats, a negedge
// monitor pops and compares every accepted beat and checks stall stability.
`timescale 1ns/1ps
module tb_spike_encoder;

    localparam int unsigned N     = 64;
    localparam int unsigned T     = 16;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned TS_W  = 4;
    localparam int unsigned DW    = 8;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [IDX_W-1:0] idx;
        logic             spike;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pix_we_i;
    logic [IDX_W-1:0] pix_addr_i;
    logic [DW-1:0]    pix_data_i;
    logic [DW-1:0]    seed_cfg_i;
    logic             start_i;
    logic             abort_i;
    logic [DW-1:0]    rand_i;
    logic [DW-1:0]    seed_o;
    logic             set_seed_o;
    logic             spike_valid_o;
    logic             spike_ready_i;
    logic             spike_o;
    logic [IDX_W-1:0] spike_idx_o;
    logic [TS_W-1:0]  timestep_o;
    logic             busy_o;
    logic             done_o;
`ifdef SPIKE_COUNT_EN
    logic [IDX_W+TS_W:0] spike_count_o;
`endif

    always #5 clk = ~clk;

    spike_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_we_i      (pix_we_i),
        .pix_addr_i    (pix_addr_i),
        .pix_data_i    (pix_data_i),
        .seed_cfg_i    (seed_cfg_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .rand_i        (rand_i),
        .seed_o        (seed_o),
        .set_seed_o    (set_seed_o),
        .spike_valid_o (spike_valid_o),
        .spike_ready_i (spike_ready_i),
        .spike_o       (spike_o),
        .spike_idx_o   (spike_idx_o),
        .timestep_o    (timestep_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count_o (spike_count_o)
`endif
    );

    beat_t      exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         sb_en = 1'b0;
    int         beats_seen = 0;
    int         done_cnt = 0;
    int         exp_spk = 0;
    bit         held = 1'b0;
    beat_t      held_b;
    beat_t      cur_b;
    beat_t      exp_b;
    logic [7:0] pix_m [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_at(input int k);
        if (k % 5 == 0) return 8'hFF;
        return 8'((k * 37 + 11) % 256);
    endfunction

    task automatic push_beat(input int k, input logic [7:0] r);
        beat_t b;
        b.ts    = TS_W'(k / N);
        b.idx   = IDX_W'(k % N);
        b.spike = r < pix_m[k % N];
        if (b.spike) exp_spk++;
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: compare accepted beats against the scoreboard, check stall stability
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (rst_n && spike_valid_o) begin
            cur_b = {timestep_o, spike_idx_o, spike_o};
            if (held) check("stall_hold", 32'(cur_b), 32'(held_b));
            if (sb_en && spike_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(cur_b), 32'hFFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", 32'(cur_b), 32'(exp_b));
                end
                beats_seen++;
            end
            held   = !spike_ready_i;
            held_b = cur_b;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d0;
        bit found;

        rst_n = 1'b0; pix_we_i = 1'b0; pix_addr_i = '0; pix_data_i = '0;
        seed_cfg_i = '0; start_i = 1'b0; abort_i = 1'b0; rand_i = '0; spike_ready_i = 1'b1;
        for (int i = 0; i < N; i++) pix_m[i] = 8'(i * 4);
        pix_m[0] = 8'd0;
        pix_m[1] = 8'd255;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {seed_o, set_seed_o, spike_valid_o, spike_o, spike_idx_o,
                                timestep_o, busy_o, done_o}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Load the pixel memory
        for (int i = 0; i < N; i++) begin
            step();
            pix_we_i = 1'b1; pix_addr_i = IDX_W'(i); pix_data_i = pix_m[i];
        end
        step();
        pix_we_i = 1'b0;

        // Test 1: asynchronous reset in the middle of ENCODE
        sb_en = 1'b0; rand_i = 8'h40;
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        repeat (20) step();
        check("busy_before_reset", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {seed_o, set_seed_o, spike_valid_o, spike_o, spike_idx_o,
                                      timestep_o, busy_o, done_o}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_idle", {busy_o, spike_valid_o, done_o}, 32'd0);
        end

        // Tests 2+3: seeding and extreme pixels at full throughput
        sb_en = 1'b1; exp_spk = 0; beats_seen = 0; d0 = done_cnt;
        seed_cfg_i = 8'hA3; spike_ready_i = 1'b1;
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        for (int k = 0; k < N * T; k++) begin
            rand_i = rand_at(k);
            push_beat(k, rand_at(k));
            if (k == 0) begin
                @(negedge clk);
                check("seed_strobe", 32'(set_seed_o), 32'd1);
                check("seed_value", 32'(seed_o), 32'hA3);
                check("seed_no_valid", 32'(spike_valid_o), 32'd0);
                check("seed_busy", 32'(busy_o), 32'd1);
            end
            if (k == 1) begin
                @(negedge clk);
                check("seed_one_cycle", 32'(set_seed_o), 32'd0);
                check("first_beat_valid", 32'(spike_valid_o), 32'd1);
            end
            step();
        end
        wait_done(20, ok);
        check("run1_done_seen", 32'(ok), 32'd1);
        check("run1_beats", 32'(beats_seen), 32'(N * T));
        check("run1_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("run1_done_once", 32'(done_cnt - d0), 32'd1);
        check("run1_idle", {busy_o, spike_valid_o}, 32'd0);
`ifdef SPIKE_COUNT_EN
        check("run1_spike_count", 32'(spike_count_o), 32'(exp_spk));
`endif

        // Start together with abort in IDLE: no run begins
        step(); start_i = 1'b1; abort_i = 1'b1;
        step(); start_i = 1'b0; abort_i = 1'b0;
        @(negedge clk);
        check("start_abort_busy", {busy_o, set_seed_o}, 32'd0);
        @(negedge clk);
        check("start_abort_still_idle", {busy_o, spike_valid_o}, 32'd0);

        // Tests 5+6: write while busy is dropped, abort at ts=3 idx=10
        sb_en = 1'b0; rand_i = 8'h40; spike_ready_i = 1'b1;
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        pix_we_i = 1'b1; pix_addr_i = 6'd5; pix_data_i = 8'h80;
        step(); pix_we_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spike_valid_o && timestep_o == 4'd3 && spike_idx_o == 6'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_target_found", 32'(found), 32'd1);
        abort_i = 1'b1;
        step(); abort_i = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        check("abort_cleared", {spike_valid_o, busy_o, done_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Test 4: restart under random backpressure; pix[5] must be unchanged
        sb_en = 1'b1; exp_spk = 0; beats_seen = 0; d0 = done_cnt; rand_i = 8'h40;
        for (int k = 0; k < N * T; k++) push_beat(k, 8'h40);
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step();
            spike_ready_i = ($urandom_range(0, 99) < 60);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
        spike_ready_i = 1'b1;
        check("run2_done_seen", 32'(ok), 32'd1);
        check("run2_beats", 32'(beats_seen), 32'(N * T));
        check("run2_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("run2_done_once", 32'(done_cnt - d0), 32'd1);
        check("run2_idle", {busy_o, spike_valid_o}, 32'd0);
`ifdef SPIKE_COUNT_EN
        check("run2_spike_count", 32'(spike_count_o), 32'(exp_spk));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
